// File: rtl/hazard_unit_if.sv
// ID-stage control bundle between the pipeline front end and the hazard unit.
// The master side drives decoder fields and the EX branch result; the slave side returns enables/flushes.
interface hazard_unit_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_wen;
  logic              id_mem_read;
  logic              id_jump;
  logic              id_jr;
  logic              ex_branch_taken;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_wen,
           id_mem_read, id_jump, id_jr, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_wen,
           id_mem_read, id_jump, id_jr, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// RAW hazard detection, redirect/jump flush control and a saturating stall counter for the ID stage.
// Define HAZARD_FWD_EN when the datapath forwards: only load-use then stalls.
module hazard_unit #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave bus
);

  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_jr_q, ex_jr_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_wen_q, mem_wen_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
`ifdef HAZARD_FWD_EN
  logic              ex_mem_read_q, ex_mem_read_d;
`endif

  logic hit_ex;
  logic hit_mem;
  logic stall;
  logic redirect;
  logic bubble;

  // r0 is hard-wired zero, so a write to it can never create a dependency.
  assign hit_ex  = ex_wen_q && (ex_rd_q != '0) &&
                   ((ex_rd_q == bus.id_rs1) || (bus.id_uses_rs2 && (ex_rd_q == bus.id_rs2)));
  assign hit_mem = mem_wen_q && (mem_rd_q != '0) &&
                   ((mem_rd_q == bus.id_rs1) || (bus.id_uses_rs2 && (mem_rd_q == bus.id_rs2)));

`ifdef HAZARD_FWD_EN
  assign stall = bus.id_valid && hit_ex && ex_mem_read_q;
`else
  assign stall = bus.id_valid && (hit_ex || hit_mem);
`endif

  assign redirect = bus.ex_branch_taken || ex_jr_q;

  always_comb begin
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    if (!rst) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (redirect) begin
      // The ID instruction is on the wrong path, so any stall or jump it asks for is moot.
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (stall) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end else if (bus.id_valid && bus.id_jump) begin
      bus.ifid_flush = 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bubble        = bus.idex_flush || !bus.id_valid;

  always_comb begin
    ex_rd_d     = bubble ? '0   : bus.id_rd;
    ex_wen_d    = bubble ? 1'b0 : bus.id_wen;
    ex_jr_d     = bubble ? 1'b0 : bus.id_jr;
    mem_rd_d    = ex_rd_q;
    mem_wen_d   = ex_wen_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && !redirect && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

`ifdef HAZARD_FWD_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_mem_read_q <= 1'b0;
    end else begin
      ex_mem_read_q <= ex_mem_read_d;
    end
  end

  assign ex_mem_read_d = bubble ? 1'b0 : bus.id_mem_read;
`else
  logic unused_mem_read;
  assign unused_mem_read = bus.id_mem_read;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_rd_q     <= '0;
      ex_wen_q    <= 1'b0;
      ex_jr_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_wen_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_wen_q    <= ex_wen_d;
      ex_jr_q     <= ex_jr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wen_q   <= mem_wen_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
